// File: rtl/alu_multicycle.sv
// alu_multicycle: N-bit ALU with single-cycle logic/add/sub and iterative shift-add MUL / restoring UDIV.
module alu_multicycle #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         zero,
  output logic [3:0]   flags
);
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [N-1:0] acc, mc, mp, rem, quo, dvs, acc_n, rem_n, quo_n, alu_res, bb;
  logic [N:0] sum, rs, diff;
  logic is_mul, is_div, is_sub, set_flags, last, accept, single;
  logic [3:0] alu_flags;
  always_comb begin
    is_mul = ALUControl == 4'b0011;
    is_div = ALUControl == 4'b0100;
    is_sub = ALUControl[2:0] == 3'b110;
    set_flags = (ALUControl == 4'b1010) || (ALUControl == 4'b1110);
    bb = is_sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, is_sub};
    alu_res = (ALUControl == 4'b0000) ? (a & b) :
              (ALUControl == 4'b0001) ? (a | b) :
              ((ALUControl[2:0] == 3'b010) || is_sub) ? sum[N-1:0] :
              (ALUControl == 4'b0111) ? b :
              is_div ? '1 : '0;
    alu_flags = {sum[N-1], sum[N-1:0] == '0, sum[N], (a[N-1] == bb[N-1]) && (sum[N-1] != a[N-1])};
    accept = (state == IDLE) && start;
    single = !is_mul && !(is_div && (b != '0));
    last = cnt == CW'(N - 1);
    acc_n = acc + (mp[0] ? mc : '0);
    // Restoring step: a borrow (diff[N]) means the trial subtraction is discarded.
    rs = {rem, quo[N-1]};
    diff = rs - {1'b0, dvs};
    rem_n = diff[N] ? rs[N-1:0] : diff[N-1:0];
    quo_n = {quo[N-2:0], !diff[N]};
    state_n = (state == IDLE) ? (start ? (is_mul ? MUL : single ? DONE : DIV) : IDLE) :
              (state == DONE) ? IDLE :
              last ? DONE : state;
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign zero = result == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      result <= '0;
      flags <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        acc <= '0;
        mc <= a;
        mp <= b;
        rem <= '0;
        quo <= a;
        dvs <= b;
        cnt <= '0;
        if (single) result <= alu_res;
        if (set_flags) flags <= alu_flags;
      end else if ((state == MUL) || (state == DIV)) begin
        cnt <= last ? '0 : cnt + CW'(1);
        acc <= acc_n;
        mc <= mc << 1;
        mp <= mp >> 1;
        rem <= rem_n;
        quo <= quo_n;
        if (last) result <= (state == MUL) ? acc_n : quo_n;
      end
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed checks of alu_multicycle at N=64 and N=8.
module tb_alu_multicycle;
  logic clk = 0, reset = 1, start = 0;
  logic [63:0] a = '0, b = '0;
  logic [3:0] ctrl = '0;
  logic busy, done, zero, busy8, done8, zero8;
  logic [63:0] result;
  logic [7:0] result8;
  logic [3:0] flags, flags8;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.N(64)) dut (.clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .ALUControl(ctrl), .busy(busy), .done(done), .result(result), .zero(zero), .flags(flags));
  alu_multicycle #(.N(8)) dut8 (.clk(clk), .reset(reset), .start(start), .a(a[7:0]), .b(b[7:0]),
    .ALUControl(ctrl), .busy(busy8), .done(done8), .result(result8), .zero(zero8), .flags(flags8));

  // Issues one op and returns cycles-to-done (200 on timeout) and cycles with busy high.
  task automatic run_op(input logic [3:0] c, input logic [63:0] x, input logic [63:0] y,
                        input bit narrow, input bit poke, output int lat, output int bc);
    @(negedge clk);
    ctrl = c; a = x; b = y; start = 1;
    lat = 0; bc = 0;
    do begin
      @(negedge clk);
      lat++;
      if (narrow ? busy8 : busy) bc++;
      a = ~x; b = ~y;
      start = poke && (lat % 2 == 0);
      if (poke) ctrl = 4'b0000;
    end while (!(narrow ? done8 : done) && lat < 200);
    start = 0; ctrl = c;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", flags); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", zero); end
    reset = 0;
  endtask

  task automatic test_adds;
    int lat, bc;
    run_op(4'b1010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, lat, bc);
    checks++; if (lat != 1) begin errors++; $display("FAIL adds_latency got %0d want 1", lat); end
    checks++; if (result !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL adds_result got %h want 8000000000000000", result); end
    checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL adds_flags got %b want 1001", flags); end
  endtask

  task automatic test_subs;
    int lat, bc;
    run_op(4'b1110, 64'd5, 64'd5, 0, 0, lat, bc);
    checks++; if (lat != 1) begin errors++; $display("FAIL subs_latency got %0d want 1", lat); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL subs_result got %h want 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL subs_zero got %b want 1", zero); end
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL subs_flags got %b want 0110", flags); end
    run_op(4'b0110, 64'd3, 64'd5, 0, 0, lat, bc);
    checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_result got %h want fffffffffffffffe", result); end
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL sub_flags_held got %b want 0110", flags); end
  endtask

  task automatic test_logic;
    logic [3:0] cs [5] = '{4'b0000, 4'b0001, 4'b0111, 4'b1111, 4'b0101};
    logic [63:0] es [5] = '{64'hF000, 64'hFFF0, 64'hFF00, 64'h0, 64'h0};
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      run_op(cs[i], 64'hF0F0, 64'hFF00, 0, 0, lat, bc);
      checks++; if (result !== es[i]) begin errors++; $display("FAIL logic_%b_result got %h want %h", cs[i], result, es[i]); end
      checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL logic_%b_flags got %b want 0110", cs[i], flags); end
    end
  endtask

  task automatic test_mul;
    int lat, bc;
    run_op(4'b0011, 64'd123456789, 64'd1000, 0, 1, lat, bc);
    checks++; if (lat != 65) begin errors++; $display("FAIL mul_latency got %0d want 65", lat); end
    checks++; if (bc != 65) begin errors++; $display("FAIL mul_busy_cycles got %0d want 65", bc); end
    checks++; if (result !== 64'd123456789000) begin errors++; $display("FAIL mul_result got %0d want 123456789000", result); end
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL mul_flags_held got %b want 0110", flags); end
  endtask

  task automatic test_udiv;
    int lat, bc;
    run_op(4'b0100, 64'd1000, 64'd7, 0, 0, lat, bc);
    checks++; if (lat != 65) begin errors++; $display("FAIL udiv_latency got %0d want 65", lat); end
    checks++; if (result !== 64'd142) begin errors++; $display("FAIL udiv_result got %0d want 142", result); end
    run_op(4'b0100, 64'd1000, 64'd0, 0, 0, lat, bc);
    checks++; if (lat != 1) begin errors++; $display("FAIL div0_latency got %0d want 1", lat); end
    checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL div0_result got %h want ffffffffffffffff", result); end
  endtask

  task automatic test_reset_mid_mul;
    int pulses = 0;
    @(negedge clk);
    ctrl = 4'b0011; a = 64'd99; b = 64'd77; start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    reset = 1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL abort_result got %h want 0", result); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL abort_flags got %b want 0000", flags); end
    reset = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", pulses); end
  endtask

  task automatic test_n8;
    int lat, bc;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    run_op(4'b1010, 64'h7F, 64'h1, 1, 0, lat, bc);
    checks++; if (lat != 1) begin errors++; $display("FAIL n8_adds_latency got %0d want 1", lat); end
    checks++; if (result8 !== 8'h80) begin errors++; $display("FAIL n8_adds_result got %h want 80", result8); end
    checks++; if (flags8 !== 4'b1001) begin errors++; $display("FAIL n8_adds_flags got %b want 1001", flags8); end
    run_op(4'b0100, 64'd200, 64'd7, 1, 0, lat, bc);
    checks++; if (lat != 9) begin errors++; $display("FAIL n8_udiv_latency got %0d want 9", lat); end
    checks++; if (result8 !== 8'd28) begin errors++; $display("FAIL n8_udiv_result got %0d want 28", result8); end
  endtask

  initial begin
    test_reset();
    test_adds();
    test_subs();
    test_logic();
    test_mul();
    test_udiv();
    test_reset_mid_mul();
    test_n8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have one parameter: N, default 64, datapath width in bits (legal range 8..64).
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  synchronous active-high reset.
REQ-005 Port start  input  1  request to begin an operation, sampled only in IDLE.
REQ-006 Port a  input  N  first operand.
REQ-007 Port b  input  N  second operand.
REQ-008 Port ALUControl  input  4  operation code; bit 3 = set flags.
REQ-009 Port busy  output  1  high while an accepted operation is in progress.
REQ-010 Port done  output  1  one-cycle pulse when result is valid.
REQ-011 Port result  output  N  registered result, held until the next done.
REQ-012 Port zero  output  1  combinational: result == 0.
REQ-013 Port flags  output  4  registered {N,Z,C,V}.

Function
REQ-014 Decode: 0000 AND, 0001 ORR, 0010/1010 ADD/ADDS, 0110/1110 SUB/SUBS, 0111 PASSB, 0011 MUL (low N bits, unsigned), 0100 UDIV (unsigned quotient); every other code SHALL yield result 0.
REQ-015 States: IDLE, MUL, DIV, DONE; busy = (state is MUL, DIV or DONE).
REQ-016 IDLE with start=1: a, b and ALUControl SHALL be captured; MUL code -> MUL, UDIV code with b!=0 -> DIV, all else -> DONE with the result computed from the captured operands.
REQ-017 start SHALL be ignored when busy=1; operands changing after capture SHALL not affect the result.
REQ-018 MUL SHALL use shift-add, one multiplier bit per cycle, for exactly N cycles, then enter DONE.
REQ-019 DIV SHALL use restoring division, one quotient bit per cycle, for exactly N cycles, then enter DONE.
REQ-020 UDIV with b=0 SHALL go directly to DONE with result all-ones.
REQ-021 Latency: done SHALL assert in the cycle after start for single-cycle ops, and N+1 cycles after start for MUL and nonzero UDIV.
REQ-022 DONE SHALL last one cycle: done=1, result updated, next state IDLE; a new start may be accepted in the cycle after done.
REQ-023 The iteration counter SHALL be $clog2(N)+1 bits wide and SHALL not wrap during an operation.
REQ-024 ADD/SUB SHALL be computed as N+1-bit sums; SUB = a + ~b + 1.
REQ-025 flags SHALL update in the DONE cycle only when ALUControl[3]=1, else hold.
REQ-026 Flag N = result[N-1]; Z = (result==0); C = carry-out of the N+1-bit sum (SUB: 1 means no borrow, a>=b unsigned); V = operand signs equal (b inverted for SUB) and result sign differs.
REQ-027 Flag-setting codes other than 1010/1110 SHALL not exist; 1xxx codes other than these SHALL yield result 0 and SHALL leave flags unchanged.

Reset
REQ-028 reset=1 SHALL force state IDLE, busy=0, done=0, result=0, flags=0000, counter=0 at the next edge.
REQ-029 reset asserted mid-MUL or mid-DIV SHALL abort the operation with no done pulse; reset takes priority over start.

Verification
REQ-030 N=64, start, 1010, a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> done next cycle, result=0x8000_0000_0000_0000, flags N=1 Z=0 C=0 V=1.
REQ-031 start, 1110, a=5, b=5 -> result=0, zero=1, flags N=0 Z=1 C=1 V=0; then 0110 a=3 b=5 -> result=0xFFFF_FFFF_FFFF_FFFE, flags unchanged.
REQ-032 start, 0011, a=123456789, b=1000 -> busy 65 cycles, done exactly 65 cycles after start, result=123456789000; start pulses during busy ignored.
REQ-033 start, 0100, a=1000, b=7 -> done 65 cycles after start, result=142; 0100 with b=0 -> done next cycle, result all-ones.
REQ-034 reset raised 10 cycles into a MUL -> next cycle busy=0, done=0, result=0, flags=0; no done pulse follows.
REQ-035 Repeat REQ-030 and REQ-033 with N=8: 0x7F+1 -> 0x80, V=1; 200/7 -> 28 in 9 cycles.
